clint: RTL
==========

# clint

Core-local interrupt/trap controller. Sits between ID/EX and the CSR file.
- Detects `ecall`, `ebreak`, `mret` and machine-timer interrupts.
- Drives the single-cycle trap write port of the CSR file (`mstatus`/`mepc`/`mcause` written together).
- Stalls the pipeline, then redirects the PC to `mtvec` or `mepc`.

## Interface
Parameters:
- `RESET_PC`, 64'h8000_0000: `jump_addr_o` value during reset.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `id_ecall_i`  in  1  instruction in ID is `ecall`
- `id_ebreak_i`  in  1  instruction in ID is `ebreak`
- `id_mret_i`  in  1  instruction in ID is `mret`
- `id_pc_i`  in  64  PC of the instruction in ID
- `ex_jump_en_i`  in  1  EX is redirecting this cycle
- `ex_jump_addr_i`  in  64  EX redirect target
- `timer_irq_i`  in  1  machine timer interrupt, level
- `mtvec_i`  in  64  current `mtvec` from CSR file
- `mstatus_i`  in  64  current `mstatus` from CSR file
- `mepc_i`  in  64  current `mepc` from CSR file
- `mcause_i`  in  64  current `mcause` from CSR file
- `clint_csr_wen_o`  out  1  write strobe to the CSR file trap port
- `mstatus_o`  out  64  `mstatus` write data
- `mepc_o`  out  64  `mepc` write data
- `mcause_o`  out  64  `mcause` write data
- `hold_o`  out  1  stall IF/ID/EX
- `jump_en_o`  out  1  PC redirect strobe
- `jump_addr_o`  out  64  PC redirect target

## Operation
FSM states: IDLE, CSR_WR, JUMP.

Event acceptance happens in IDLE only. Priority:
1. `ecall`: cause 64'd11, epc = `id_pc_i`.
2. `ebreak`: cause 64'd3, epc = `id_pc_i`.
3. `mret`.
4. Timer interrupt: taken only when `timer_irq_i`=1 and `mstatus_i[3]` (MIE)=1.
   - cause 64'h8000_0000_0000_0007.
   - epc = `ex_jump_addr_i` if `ex_jump_en_i`, else `id_pc_i`.

On acceptance:
- Latch kind, cause, epc and the data for the next `mstatus`.
- Go to CSR_WR.
- Unaccepted lower-priority events are dropped. A level IRQ is re-evaluated in a later IDLE.

`mstatus` update:
- Trap (exception or interrupt): `mstatus_o` = `mstatus_i` with bit7 (MPIE) ← bit3 (MIE), bit3 ← 0. All other bits are unchanged.
- `mret`: bit3 ← bit7, bit7 ← 1.

CSR_WR:
- `clint_csr_wen_o`=1 for exactly one cycle.
- Trap: `mepc_o` = latched epc, `mcause_o` = latched cause.
- `mret`: `mepc_o` = `mepc_i`, `mcause_o` = `mcause_i` (rewritten unchanged).
- Then go to JUMP.

JUMP:
- `jump_en_o`=1 for one cycle.
- `jump_addr_o` = {`mtvec_i`[63:2], 2'b00} for a trap (direct mode only). For `mret` it is the `mepc_i` value sampled at acceptance.
- Then go to IDLE.

Idle outputs:
- Outside CSR_WR, `clint_csr_wen_o`=0 and `mepc_o`/`mcause_o`/`mstatus_o`=0.
- Outside JUMP, `jump_en_o`=0 and `jump_addr_o`=0.

## Timing
- Acceptance at cycle N (IDLE). `hold_o`=1 combinationally in N, then registered through N+1 (CSR_WR) and N+2 (JUMP). `hold_o`=0 from N+3.
- CSR write takes effect at the N+1→N+2 edge.
- The redirect is issued in N+2. The earliest next acceptance is N+3.
- The trap entry therefore sees MIE=0, so a still-high `timer_irq_i` is not retaken until after `mret`.
- Events arriving during CSR_WR/JUMP are ignored. ID is held, so exceptions re-present at N+3.
- Simultaneous `ecall` and `timer_irq_i`: `ecall` wins. The IRQ is not taken because MIE is now 0.
- Simultaneous `ex_jump_en_i` and a non-interrupt event in ID: the event is ignored, because the ID instruction is being flushed.
- Reset (`rst`=0) in any state, including mid-sequence:
  - Next state IDLE.
  - All outputs 0, except `jump_addr_o` = `RESET_PC`.
  - Latched fields cleared.
  - No partial CSR write is completed.

## Structure
- Shared package `clint_pkg`:
  - State enum (IDLE/CSR_WR/JUMP).
  - Cause constants: CAUSE_ECALL_M=11, CAUSE_BREAKPOINT=3, CAUSE_MTIMER_IRQ=64'h8000_0000_0000_0007.
  - Bit indices MSTATUS_MIE=3, MSTATUS_MPIE=7.
  - Event-kind enum (NONE/EXC/IRQ/MRET).
- Single module with no sub-module. Priority encode, latch and FSM fit in one file of roughly 180 lines.

## Test plan
- **Ecall:** `ecall` at `id_pc_i`=0x8000_0010, `mtvec_i`=0x8000_0103, `mstatus_i`=0x8. Expect:
  - N+1: wen=1, mepc=0x8000_0010, mcause=11, mstatus=0x80.
  - N+2: jump to 0x8000_0100.
  - `hold_o` high N..N+2.
- **Mret:** `mret` with `mepc_i`=0x8000_0014, `mstatus_i`=0x80. Expect:
  - N+1: mstatus_o=0x88, mepc_o=0x8000_0014.
  - N+2: jump to 0x8000_0014.
- **Timer IRQ, enabled:** `timer_irq_i`=1, MIE=1, `ex_jump_en_i`=1 to 0x8000_0200. Expect mepc_o=0x8000_0200, mcause_o=0x8000_0000_0000_0007.
- **Timer IRQ, masked:** `timer_irq_i`=1 with MIE=0 for 10 cycles. Expect `hold_o`/wen/jump all stay 0.
- **Simultaneous ecall and IRQ:** both asserted, MIE=1. Expect mcause_o=11, and exactly one CSR write in 4 cycles.
- **Reset mid-sequence:** `rst`=0 during CSR_WR. Expect:
  - Next cycle wen=0, `hold_o`=0, `jump_addr_o`=`RESET_PC`.
  - After release, no jump is issued.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared types and constants for the core-local interrupt/trap controller.
package clint_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CSR_WR = 2'd1,
    ST_JUMP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EXC  = 2'd1,
    EV_IRQ  = 2'd2,
    EV_MRET = 2'd3
  } ev_kind_e;

  localparam logic [63:0] CAUSE_ECALL_M    = 64'd11;
  localparam logic [63:0] CAUSE_BREAKPOINT = 64'd3;
  localparam logic [63:0] CAUSE_MTIMER_IRQ = 64'h8000_0000_0000_0007;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // Trap entry: stash MIE into MPIE, then disable interrupts.
  function automatic logic [63:0] trap_mstatus(input logic [63:0] m);
    logic [63:0] r;
    r               = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, then set MPIE.
  function automatic logic [63:0] mret_mstatus(input logic [63:0] m);
    logic [63:0] r;
    r               = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupt/trap controller.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | accept ecall/ebreak/mret/timer irq; hold only on accept
// ST_CSR_WR | one-cycle trap write of mstatus/mepc/mcause, pipeline held
// ST_JUMP   | one-cycle PC redirect to mtvec (trap) or mepc (mret)
module clint
  import clint_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_ecall_i,
  input  logic        id_ebreak_i,
  input  logic        id_mret_i,
  input  logic [63:0] id_pc_i,
  input  logic        ex_jump_en_i,
  input  logic [63:0] ex_jump_addr_i,
  input  logic        timer_irq_i,
  input  logic [63:0] mtvec_i,
  input  logic [63:0] mstatus_i,
  input  logic [63:0] mepc_i,
  input  logic [63:0] mcause_i,
  output logic        clint_csr_wen_o,
  output logic [63:0] mstatus_o,
  output logic [63:0] mepc_o,
  output logic [63:0] mcause_o,
  output logic        hold_o,
  output logic        jump_en_o,
  output logic [63:0] jump_addr_o
);

  state_e      r_state;
  ev_kind_e    r_kind;
  logic [63:0] r_cause;
  logic [63:0] r_epc;
  logic [63:0] r_mstatus;
  logic [63:0] r_mret_pc;

  ev_kind_e    w_ev;
  logic [63:0] w_cause;
  logic [63:0] w_epc;
  logic [63:0] w_mstatus;
  logic        w_accept;
  logic        w_unused;

  // Only direct-mode mtvec is supported, so the mode bits are ignored.
  assign w_unused = &{1'b0, mtvec_i[1:0]};

  // Priority-encode pending events; an EX redirect flushes the ID instruction,
  // so only the interrupt can still be taken in that cycle.
  always_comb begin
    w_ev      = EV_NONE;
    w_cause   = '0;
    w_epc     = '0;
    w_mstatus = '0;
    if (id_ecall_i && !ex_jump_en_i) begin
      w_ev      = EV_EXC;
      w_cause   = CAUSE_ECALL_M;
      w_epc     = id_pc_i;
      w_mstatus = trap_mstatus(mstatus_i);
    end else if (id_ebreak_i && !ex_jump_en_i) begin
      w_ev      = EV_EXC;
      w_cause   = CAUSE_BREAKPOINT;
      w_epc     = id_pc_i;
      w_mstatus = trap_mstatus(mstatus_i);
    end else if (id_mret_i && !ex_jump_en_i) begin
      w_ev      = EV_MRET;
      w_mstatus = mret_mstatus(mstatus_i);
    end else if (timer_irq_i && mstatus_i[MSTATUS_MIE]) begin
      w_ev      = EV_IRQ;
      w_cause   = CAUSE_MTIMER_IRQ;
      w_epc     = ex_jump_en_i ? ex_jump_addr_i : id_pc_i;
      w_mstatus = trap_mstatus(mstatus_i);
    end
  end

  assign w_accept = (r_state == ST_IDLE) && (w_ev != EV_NONE);

  // Sequence state and latch the accepted event's fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_kind    <= EV_NONE;
      r_cause   <= '0;
      r_epc     <= '0;
      r_mstatus <= '0;
      r_mret_pc <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_CSR_WR;
            r_kind    <= w_ev;
            r_cause   <= w_cause;
            r_epc     <= w_epc;
            r_mstatus <= w_mstatus;
            r_mret_pc <= mepc_i;
          end
        end
        ST_CSR_WR: r_state <= ST_JUMP;
        ST_JUMP:   r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are gated by reset so a write or redirect is never half-issued.
  always_comb begin
    clint_csr_wen_o = 1'b0;
    mstatus_o       = '0;
    mepc_o          = '0;
    mcause_o        = '0;
    hold_o          = 1'b0;
    jump_en_o       = 1'b0;
    jump_addr_o     = '0;
    if (!rst) begin
      jump_addr_o = RESET_PC;
    end else begin
      case (r_state)
        ST_IDLE: hold_o = w_accept;
        ST_CSR_WR: begin
          hold_o          = 1'b1;
          clint_csr_wen_o = 1'b1;
          mstatus_o       = r_mstatus;
          if (r_kind == EV_MRET) begin
            mepc_o   = mepc_i;
            mcause_o = mcause_i;
          end else begin
            mepc_o   = r_epc;
            mcause_o = r_cause;
          end
        end
        ST_JUMP: begin
          hold_o    = 1'b1;
          jump_en_o = 1'b1;
          if (r_kind == EV_MRET) begin
            jump_addr_o = r_mret_pc;
          end else begin
            jump_addr_o = {mtvec_i[63:2], 2'b00};
          end
        end
        default: hold_o = 1'b0;
      endcase
    end
  end

endmodule
